a2d_rr_intf: RTL

Round-robin SPI master for the Segway's 8-channel, 12-bit A2D converter. Each `nxt` pulse converts the next channel in a fixed three-entry rotation: left load cell, right load cell, battery. The block runs two 16-bit SPI transactions per conversion and updates the matching result register. It sits upstream of the digital core, which consumes `lft_ld`, `rght_ld` and `batt` and generates `nxt`.

---
 rtl/a2d_rr_intf.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/a2d_rr_intf.sv
// Round-robin SPI (mode 3) master for the 8-channel 12-bit A2D: left load, right load, battery.
// Define A2D_BATT_AVG_EN to report batt as the running average of the last 4 battery samples.
module a2d_rr_intf #(
  parameter logic [2:0] LFT_CH  = 3'd0,
  parameter logic [2:0] RGHT_CH = 3'd4,
  parameter logic [2:0] BATT_CH = 3'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  // Handshake: nxt acts as a request that is only accepted in IDLE; cnv_cmplt is a one-clk
  // completion strobe, and the result registers hold their value until the next DONE.
  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  div;
  logic [3:0]  bit_cnt;
  logic [15:0] tx_shft;
  logic [11:0] rx_shft;
  logic [1:0]  ptr;
  logic [2:0]  ch;
  logic [15:0] cmd_word;
  logic        xfer, bit_end, last_bit;
  logic        start_xfer, clr_div, load_res;

  always_comb begin
    case (ptr)
      2'd0:    ch = LFT_CH;
      2'd1:    ch = RGHT_CH;
      default: ch = BATT_CH;
    endcase
  end

  assign cmd_word = {2'b00, ch, 11'h000};
  assign xfer     = (state == CMD) || (state == READ);
  assign bit_end  = (div == 5'd31);
  assign last_bit = (bit_cnt == 4'd15);

  assign SS_n = ~xfer;
  assign SCLK = ~xfer | div[4];
  assign MOSI = tx_shft[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_xfer = 1'b0;
    clr_div    = 1'b0;
    load_res   = 1'b0;
    case (state)
      IDLE: if (nxt) begin
        state_nxt  = CMD;
        start_xfer = 1'b1;
      end
      CMD: if (bit_end && last_bit) begin
        state_nxt = GAP;
        clr_div   = 1'b1;
      end
      // div doubles as the 32-clk gap timer between the two transactions
      GAP: if (bit_end) begin
        state_nxt  = READ;
        start_xfer = 1'b1;
      end
      READ: if (bit_end && last_bit) begin
        state_nxt = DONE;
        load_res  = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      bit_cnt <= '0;
      tx_shft <= '0;
      rx_shft <= '0;
    end else begin
      if (start_xfer || clr_div) div <= '0;
      else if (state != IDLE)    div <= div + 5'd1;
      if (start_xfer)               bit_cnt <= '0;
      else if (xfer && bit_end)     bit_cnt <= bit_cnt + 4'd1;
      if (start_xfer)                           tx_shft <= cmd_word;
      else if (xfer && bit_end && !last_bit)    tx_shft <= {tx_shft[14:0], 1'b0};
      // only the last 12 of the 16 received bits form the result
      if (xfer && (div == 5'd15)) rx_shft <= {rx_shft[10:0], MISO};
    end
  end

  // Results become visible together with the cnv_cmplt strobe during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 2'd0;
      lft_ld    <= '0;
      rght_ld   <= '0;
      cnv_cmplt <= 1'b0;
    end else begin
      cnv_cmplt <= load_res;
      if (load_res) begin
        if (ptr == 2'd0) lft_ld  <= rx_shft;
        if (ptr == 2'd1) rght_ld <= rx_shft;
        ptr <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
      end
    end
  end

`ifdef A2D_BATT_AVG_EN
  logic [11:0] hist [4];
  logic        hist_vld;
  logic [13:0] hist_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      hist_vld <= 1'b0;
    end else if (load_res && (ptr == 2'd2)) begin
      // first sample after reset fills the whole history
      hist_vld <= 1'b1;
      hist[0]  <= rx_shft;
      hist[1]  <= hist_vld ? hist[0] : rx_shft;
      hist[2]  <= hist_vld ? hist[1] : rx_shft;
      hist[3]  <= hist_vld ? hist[2] : rx_shft;
    end
  end

  assign hist_sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
  assign batt     = 12'(hist_sum >> 2);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           batt <= '0;
    else if (load_res && (ptr == 2'd2))   batt <= rx_shft;
  end
`endif

endmodule
